// File: rtl/jlsemi_util_smic_efuse_pkg.sv
// Shared state encoding and default sizing for the SMIC efuse sequencer.
package jlsemi_util_smic_efuse_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 6;
  localparam int unsigned DEF_NUM_WORDS  = 8;

  typedef enum logic [2:0] {
    RST_WAIT,
    LD_ISSUE,
    LD_WAIT,
    ARB,
    ISSUE,
    WAIT
  } efuse_seq_state_e;

endpackage

// File: rtl/jlsemi_util_smic_efuse_seq.sv
// Efuse sequencer: autoloads a shadow copy after reset, then serves test/host requests.
// Optional program lock compiled in with JLSEMI_EFUSE_SEQ_LOCK_EN.
module jlsemi_util_smic_efuse_seq
  import jlsemi_util_smic_efuse_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_WORDS  = DEF_NUM_WORDS,
  parameter int unsigned LOCK_ADDR  = NUM_WORDS - 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    tst_req,
  input  logic                    tst_write,
  input  logic [ADDR_WIDTH-1:0]   tst_addr,
  input  logic [15:0]             tst_wdata,
  input  logic                    host_req,
  input  logic                    host_write,
  input  logic [ADDR_WIDTH-1:0]   host_addr,
  input  logic [15:0]             host_wdata,
  output logic                    tst_ack,
  output logic                    host_ack,
  output logic [15:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic                    efuse_en,
  output logic                    write_en,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [15:0]             wdata,
  input  logic [15:0]             rdata,
  input  logic                    rdata_vld,
  input  logic                    ready,
  output logic [NUM_WORDS*16-1:0] shadow_data,
  output logic                    load_done,
  output logic                    busy
);

  if (NUM_WORDS < 1 || NUM_WORDS > (1 << ADDR_WIDTH) || LOCK_ADDR >= NUM_WORDS) begin : g_param_chk
    $error("jlsemi_util_smic_efuse_seq: NUM_WORDS/LOCK_ADDR out of range");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);

  efuse_seq_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ld_cnt_q, ld_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic                    gnt_host_q, gnt_host_d;
  logic                    tst_ack_q, tst_ack_d;
  logic                    host_ack_q, host_ack_d;
  logic                    err_q, err_d;
  logic [15:0]             rsp_rdata_q, rsp_rdata_d;
  logic                    load_done_q, load_done_d;
  logic [15:0]             rdata_q;
  logic [NUM_WORDS*16-1:0] shadow_q;
  logic                    ld_store, wr_update;
  logic [15:0]             rd_word;
  logic                    locked;
  logic                    sel_host, sel_write;

`ifdef JLSEMI_EFUSE_SEQ_LOCK_EN
  assign locked = shadow_q[16*LOCK_ADDR+15];
`else
  assign locked = 1'b0;
`endif

  // Read data may arrive with or before ready; take the live value if both coincide.
  assign rd_word   = rdata_vld ? rdata : rdata_q;
  assign sel_host  = !tst_req;
  assign sel_write = sel_host ? host_write : tst_write;

  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    gnt_host_d  = gnt_host_q;
    tst_ack_d   = 1'b0;
    host_ack_d  = 1'b0;
    err_d       = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    load_done_d = load_done_q;
    ld_store    = 1'b0;
    wr_update   = 1'b0;
    case (state_q)
      RST_WAIT: begin
        state_d  = LD_ISSUE;
        ld_cnt_d = '0;
        addr_d   = '0;
        wdata_d  = '0;
        we_d     = 1'b0;
      end
      LD_ISSUE: state_d = LD_WAIT;
      LD_WAIT: begin
        if (ready) begin
          ld_store = 1'b1;
          if (ld_cnt_q == LAST_WORD) begin
            load_done_d = 1'b1;
            state_d     = ARB;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
            addr_d   = ld_cnt_q + 1'b1;
            state_d  = LD_ISSUE;
          end
        end
      end
      ARB: begin
        // Skip the ack cycle: the finishing requester still holds req until it sees ack.
        if (!tst_ack_q && !host_ack_q && (tst_req || host_req)) begin
          if (locked && sel_write) begin
            tst_ack_d   = !sel_host;
            host_ack_d  = sel_host;
            err_d       = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            gnt_host_d = sel_host;
            addr_d     = sel_host ? host_addr : tst_addr;
            wdata_d    = sel_host ? host_wdata : tst_wdata;
            we_d       = sel_write;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (ready) begin
          tst_ack_d   = !gnt_host_q;
          host_ack_d  = gnt_host_q;
          rsp_rdata_d = rd_word;
          wr_update   = we_q;
          state_d     = ARB;
        end
      end
      default: state_d = RST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= RST_WAIT;
      ld_cnt_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      gnt_host_q  <= 1'b0;
      tst_ack_q   <= 1'b0;
      host_ack_q  <= 1'b0;
      err_q       <= 1'b0;
      rsp_rdata_q <= '0;
      load_done_q <= 1'b0;
      rdata_q     <= '0;
      shadow_q    <= '0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      gnt_host_q  <= gnt_host_d;
      tst_ack_q   <= tst_ack_d;
      host_ack_q  <= host_ack_d;
      err_q       <= err_d;
      rsp_rdata_q <= rsp_rdata_d;
      load_done_q <= load_done_d;
      if (rdata_vld) rdata_q <= rdata;
      // Out-of-range write addresses match no word here and leave the shadow alone.
      for (int unsigned k = 0; k < NUM_WORDS; k++) begin
        if (ld_store && ld_cnt_q == k[ADDR_WIDTH-1:0])
          shadow_q[16*k +: 16] <= rd_word;
        else if (wr_update && addr_q == k[ADDR_WIDTH-1:0])
          shadow_q[16*k +: 16] <= shadow_q[16*k +: 16] | wdata_q;
      end
    end
  end

  assign efuse_en    = (state_q == LD_ISSUE) || (state_q == ISSUE);
  assign write_en    = we_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign tst_ack     = tst_ack_q;
  assign host_ack    = host_ack_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = err_q;
  assign shadow_data = shadow_q;
  assign load_done   = load_done_q;
  assign busy        = !((state_q == ARB) && !tst_req && !host_req);

endmodule
